rtc_timer: RTL and testbench
============================

// Module: rtc_timer
// PURPOSE
//  Memory-mapped real-time counter on the 6502 system bus, instantiated in the DUT as u_rtc.
//  A programmable prescaler divides i_clk into ticks; each tick increments a 32-bit counter.
//  The counter is exported as r_output/o_count for sim monitors. The CPU reads and writes it
//  through eight byte registers. It raises a level IRQ per tick.
//  Setup code programs it; the CPU consumes its counter and IRQ.
// PARAMETERS
//  PRESCALE_RST  16'd49  prescaler reload value after reset (tick period = PRESCALE+1 clocks)
//  COUNT_W       32      counter width; fixed at 32, not to be changed (byte map assumes 4 bytes)
// PORTS
//  i_clk     in   1   system clock
//  i_rst     in   1   synchronous reset, active-high
//  i_cs      in   1   chip select, decoded upstream from CPU address
//  i_we      in   1   1 = CPU write, 0 = read
//  i_addr    in   3   register offset
//  i_data    in   8   CPU write data
//  o_data    out  8   read data; combinational; 8'h00 when !(i_cs && !i_we)
//  o_irq     out  1   level IRQ = status.pend & ctrl.irq_en
//  o_count   out  32  live counter (r_output)
// BEHAVIOUR
//  Register map:
//   0 CTRL    [0] en  [1] irq_en  [2] clr (write-only, self-clears, reads 0)  [7:3] read 0
//   1 STATUS  [0] pend; write 1 clears; write 0 has no effect
//   2/3 PRESCALE lo/hi
//   4..7 COUNT byte0..3
//  Reset: ctrl=0, pend=0, prescale=PRESCALE_RST, prescaler cnt=0, count=0,
//   snapshot=0, staging=0, o_irq=0.
//  All register side effects occur on the i_clk edge where i_cs is high.
//  Prescaler:
//   - Counts 0..PRESCALE only while en=1.
//   - tick=1 for one cycle when the counter equals PRESCALE; it then wraps to 0.
//   - PRESCALE=0 gives a tick every clock.
//   - While en=0 the prescaler holds its value.
//  Counter:
//   - Increments by 1 on tick.
//   - Wraps 32'hFFFF_FFFF -> 0 with no flag.
//  IRQ:
//   - tick sets pend regardless of irq_en.
//   - A tick and a STATUS clear in the same cycle: set wins.
//  Writing PRESCALE:
//   - Takes effect next cycle.
//   - If the prescaler cnt is above the new value, the prescaler resets to 0; otherwise it continues.
//  Atomic read:
//   - A read of offset 4 returns live byte0.
//   - The same edge latches live bytes 3:1 into a snapshot.
//   - Offsets 5..7 return the snapshot, never the live count.
//  Atomic write:
//   - Writes to 4..6 load staging bytes 0..2.
//   - A write to 7 commits {i_data, staging[23:0]} to the counter.
//   - The commit also resets the prescaler cnt to 0.
//   - Commit beats a same-cycle tick.
//  CTRL.clr=1:
//   - Counter=0, prescaler cnt=0, pend=0 that edge.
//   - en and irq_en are written from the same byte.
//  Reset mid-operation restores all reset values in one cycle; the staging and snapshot contents are lost.
//  Reads have no side effects except the offset-4 snapshot.
// STRUCTURE
//  rtc_pkg:
//   - Offset localparams REG_CTRL..REG_CNT3.
//   - CTRL bit indices CTRL_EN, CTRL_IRQEN, CTRL_CLR.
//   - STATUS bit STAT_PEND.
//   - typedef rtc_ctrl_t (packed).
//  Sub-module rtc_prescaler (i_clk, i_rst, i_en, i_load_zero, i_prescale[15:0], o_tick) holds the divider.
//  The top holds the register file, counter, snapshot and staging.
// TESTING
//  1. Reset; read all offsets -> 00, 00, 31, 00, 00, 00, 00, 00; o_irq=0; o_count=0.
//  2. PRESCALE=3, CTRL=01 -> o_count increments every 4 clocks; 40 clocks after enable, o_count=10.
//  3. Commit 32'h00FF_FFFF via offsets 4..7, then run PRESCALE=0.
//     Read 4 at 00FF_FFFF -> FF; snapshot holds FF FF 00 while live rolls to 0100_0000.
//     Reads 5,6,7 return FF, FF, 00.
//  4. CTRL=03, PRESCALE=0: o_irq rises the cycle after the first tick.
//     Write STATUS=01 on a tick cycle -> pend stays 1.
//     Clear with en=0 -> o_irq=0.
//  5. Load FFFF_FFFE, en=1, PRESCALE=0 -> counts FFFF_FFFF, 0000_0000, 0000_0001.
//  6. Running at count 5: CTRL=05 -> count=0 next cycle and CTRL reads 01.
//     Assert i_rst mid-count -> all reset values next cycle.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC timer: register offsets, CTRL/STATUS bit positions
// and the packed control register layout.
package rtc_pkg;

  localparam logic [15:0] PRESCALE_RST_DEF = 16'd49;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_PRE_LO = 3'd2;
  localparam logic [2:0] REG_PRE_HI = 3'd3;
  localparam logic [2:0] REG_CNT0   = 3'd4;
  localparam logic [2:0] REG_CNT1   = 3'd5;
  localparam logic [2:0] REG_CNT2   = 3'd6;
  localparam logic [2:0] REG_CNT3   = 3'd7;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_CLR   = 2;
  localparam int STAT_PEND  = 0;

  typedef struct packed {
    logic irq_en;
    logic en;
  } rtc_ctrl_t;

  // CTRL read-back byte: clr and the upper bits always read as zero.
  function automatic logic [7:0] ctrl_to_byte(input rtc_ctrl_t c);
    return {6'b00_0000, c.irq_en, c.en};
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Programmable clock divider: emits a one-cycle tick when the phase counter reaches
// the prescale value, then wraps to zero. Holds while disabled.
module rtc_prescaler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_load_zero,
  input  logic [15:0] i_prescale,
  output logic        o_tick
);

  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;

  // Next phase; a phase above a freshly lowered prescale value restarts from zero.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (i_load_zero) begin
      cnt_nxt_s = 16'd0;
    end else if (i_en) begin
      if (cnt_r >= i_prescale) begin
        cnt_nxt_s = 16'd0;
      end else begin
        cnt_nxt_s = cnt_r + 16'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Phase counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign o_tick = i_en && (cnt_r == i_prescale);

endmodule

// File: rtl/rtc_timer.sv
// Memory-mapped 32-bit real-time counter with programmable prescaler, atomic
// multi-byte read/write of the count, and a level IRQ per tick.
module rtc_timer
  import rtc_pkg::*;
#(
  parameter logic [15:0] PRESCALE_RST = PRESCALE_RST_DEF,
  parameter int          COUNT_W      = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cs,
  input  logic               i_we,
  input  logic [2:0]         i_addr,
  input  logic [7:0]         i_data,
  output logic [7:0]         o_data,
  output logic               o_irq,
  output logic [COUNT_W-1:0] o_count
);

  rtc_ctrl_t          ctrl_r;
  logic               pend_r;
  logic [15:0]        prescale_r;
  logic [COUNT_W-1:0] count_r;
  logic [23:0]        snap_r;
  logic [23:0]        stage_r;

  logic               wr_s;
  logic               rd_s;
  logic               clr_s;
  logic               commit_s;
  logic               stat_clr_s;
  logic               snap_s;
  logic               tick_s;
  logic [COUNT_W-1:0] count_nxt_s;
  logic               pend_nxt_s;
  logic [7:0]         rd_data_s;

  assign wr_s       = i_cs && i_we;
  assign rd_s       = i_cs && !i_we;
  assign clr_s      = wr_s && (i_addr == REG_CTRL) && i_data[CTRL_CLR];
  assign commit_s   = wr_s && (i_addr == REG_CNT3);
  assign stat_clr_s = wr_s && (i_addr == REG_STATUS) && i_data[STAT_PEND];
  assign snap_s     = rd_s && (i_addr == REG_CNT0);

  rtc_prescaler u_prescaler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (ctrl_r.en),
    .i_load_zero (clr_s || commit_s),
    .i_prescale  (prescale_r),
    .o_tick      (tick_s)
  );

  // Counter and pending flag: clear beats commit beats tick; a tick beats a STATUS clear.
  always_comb begin
    count_nxt_s = count_r;
    pend_nxt_s  = pend_r;
    if (clr_s) begin
      count_nxt_s = 32'd0;
    end else if (commit_s) begin
      count_nxt_s = {i_data, stage_r};
    end else if (tick_s) begin
      count_nxt_s = count_r + 32'd1;
    end else begin
      count_nxt_s = count_r;
    end
    if (clr_s) begin
      pend_nxt_s = 1'b0;
    end else if (tick_s) begin
      pend_nxt_s = 1'b1;
    end else if (stat_clr_s) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // Register file, counter, snapshot and staging.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_r     <= rtc_ctrl_t'(2'b00);
      pend_r     <= 1'b0;
      prescale_r <= PRESCALE_RST;
      count_r    <= 32'd0;
      snap_r     <= 24'd0;
      stage_r    <= 24'd0;
    end else begin
      count_r <= count_nxt_s;
      pend_r  <= pend_nxt_s;
      if (snap_s) begin
        snap_r <= count_r[31:8];
      end
      if (wr_s) begin
        case (i_addr)
          REG_CTRL: begin
            ctrl_r.en     <= i_data[CTRL_EN];
            ctrl_r.irq_en <= i_data[CTRL_IRQEN];
          end
          REG_PRE_LO: prescale_r[7:0]  <= i_data;
          REG_PRE_HI: prescale_r[15:8] <= i_data;
          REG_CNT0:   stage_r[7:0]     <= i_data;
          REG_CNT1:   stage_r[15:8]    <= i_data;
          REG_CNT2:   stage_r[23:16]   <= i_data;
          default: begin
          end
        endcase
      end
    end
  end

  // Read mux; bytes 1..3 of the count come only from the snapshot.
  always_comb begin
    rd_data_s = 8'h00;
    if (rd_s) begin
      case (i_addr)
        REG_CTRL:   rd_data_s = ctrl_to_byte(ctrl_r);
        REG_STATUS: rd_data_s = {7'b000_0000, pend_r};
        REG_PRE_LO: rd_data_s = prescale_r[7:0];
        REG_PRE_HI: rd_data_s = prescale_r[15:8];
        REG_CNT0:   rd_data_s = count_r[7:0];
        REG_CNT1:   rd_data_s = snap_r[7:0];
        REG_CNT2:   rd_data_s = snap_r[15:8];
        REG_CNT3:   rd_data_s = snap_r[23:16];
        default:    rd_data_s = 8'h00;
      endcase
    end else begin
      rd_data_s = 8'h00;
    end
  end

  assign o_data  = rd_data_s;
  assign o_irq   = pend_r && ctrl_r.irq_en;
  assign o_count = count_r;

endmodule

// File: tb/tb_rtc_timer.sv
// Scoreboard bench for rtc_timer: directed scenarios plus random bus traffic,
// checked against a behavioural model of the register map.
module tb_rtc_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        irq;
  logic [31:0] count;

  always #5 clk = ~clk;

  rtc_timer dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_cs    (cs),
    .i_we    (we),
    .i_addr  (addr),
    .i_data  (wdata),
    .o_data  (rdata),
    .o_irq   (irq),
    .o_count (count)
  );

  // Behavioural model state
  bit          m_en, m_irq_en, m_pend;
  logic [15:0] m_pre, m_div;
  logic [31:0] m_count;
  logic [7:0]  m_snap [3];
  logic [7:0]  m_stage [3];

  typedef struct {
    logic [7:0]  data;
    logic [31:0] cnt;
    logic        irq;
  } exp_t;

  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  bit   checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_irq_en = 1'b0; m_pend = 1'b0;
    m_pre = 16'd49; m_div = 16'd0; m_count = 32'd0;
    for (int k = 0; k < 3; k++) begin
      m_snap[k] = 8'h00;
      m_stage[k] = 8'h00;
    end
  endtask

  function automatic logic [7:0] exp_read();
    if (!(cs && !we)) return 8'h00;
    case (addr)
      3'd0:    return {6'd0, m_irq_en, m_en};
      3'd1:    return {7'd0, m_pend};
      3'd2:    return m_pre[7:0];
      3'd3:    return m_pre[15:8];
      3'd4:    return m_count[7:0];
      3'd5:    return m_snap[0];
      3'd6:    return m_snap[1];
      default: return m_snap[2];
    endcase
  endfunction

  // Apply one clock edge's worth of register-map rules to the model.
  task automatic model_step();
    bit tick, wr, clr, commit;
    if (rst) begin
      model_reset();
      return;
    end
    tick   = m_en && (m_div == m_pre);
    wr     = cs && we;
    clr    = wr && (addr == 3'd0) && wdata[2];
    commit = wr && (addr == 3'd7);
    if (cs && !we && addr == 3'd4)
      for (int k = 0; k < 3; k++) m_snap[k] = 8'(m_count >> (8 * (k + 1)));
    if (clr || commit) m_div = 16'd0;
    else if (m_en) m_div = (m_div >= m_pre) ? 16'd0 : m_div + 16'd1;
    if (clr) m_count = 32'd0;
    else if (commit) m_count = {wdata, m_stage[2], m_stage[1], m_stage[0]};
    else if (tick) m_count = m_count + 32'd1;
    if (clr) m_pend = 1'b0;
    else if (tick) m_pend = 1'b1;
    else if (wr && addr == 3'd1 && wdata[0]) m_pend = 1'b0;
    if (wr) begin
      case (addr)
        3'd0: begin m_en = wdata[0]; m_irq_en = wdata[1]; end
        3'd2: m_pre[7:0] = wdata;
        3'd3: m_pre[15:8] = wdata;
        3'd4, 3'd5, 3'd6: m_stage[addr - 3'd4] = wdata;
        default: ;
      endcase
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit w, input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    rst = r; cs = c; we = w; addr = a; wdata = d;
    if (checking) begin
      e.data = exp_read();
      e.cnt  = m_count;
      e.irq  = m_pend && m_irq_en;
      sb_q.push_back(e);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b1, a, d);
    advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      advance();
    end
  endtask

  task automatic read_expect(input logic [2:0] a, input logic [7:0] exp, input string name);
    drive(1'b0, 1'b1, 1'b0, a, 8'h00);
    #2;
    check(name, {24'd0, rdata}, {24'd0, exp});
    advance();
  endtask

  // Monitor: every checked cycle the DUT presents o_data/o_count/o_irq; compare at negedge.
  always @(negedge clk) begin
    if (checking) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got empty queue, expected an entry (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_o_data", {24'd0, rdata}, {24'd0, e.data});
        check("sb_o_count", count, e.cnt);
        check("sb_o_irq", {31'd0, irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] reset_vals [8];

  initial begin
    bit r, c, w;
    logic [2:0] a;
    logic [7:0] d;
    reset_vals = '{8'h00, 8'h00, 8'h31, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;

    // 1: reset state
    check("rst_count", count, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 8; i++) read_expect(3'(i), reset_vals[i], "rst_read");

    // 2: PRESCALE=3 -> one count per 4 clocks
    wr(3'd2, 8'd3); wr(3'd3, 8'd0); wr(3'd0, 8'h01);
    idle(40);
    check("div4_count40", count, 32'd10);

    // 3: atomic read across a byte-1..3 carry
    wr(3'd0, 8'h00);
    wr(3'd4, 8'hFF); wr(3'd5, 8'hFF); wr(3'd6, 8'hFF); wr(3'd7, 8'h00);
    check("commit_value", count, 32'h00FF_FFFF);
    wr(3'd2, 8'd0);
    wr(3'd0, 8'h01);
    read_expect(3'd4, 8'hFF, "atomic_b0");
    check("live_rolled", count, 32'h0100_0000);
    read_expect(3'd5, 8'hFF, "atomic_b1");
    read_expect(3'd6, 8'hFF, "atomic_b2");
    read_expect(3'd7, 8'h00, "atomic_b3");
    wr(3'd0, 8'h00);

    // 4: IRQ behaviour
    wr(3'd1, 8'h01);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    wr(3'd0, 8'h03);
    check("irq_before_tick", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_rise", {31'd0, irq}, 32'd1);
    wr(3'd1, 8'h01);
    check("set_beats_clear", {31'd0, irq}, 32'd1);
    wr(3'd0, 8'h02);
    wr(3'd1, 8'h01);
    check("irq_clear_stopped", {31'd0, irq}, 32'd0);

    // 5: wrap
    wr(3'd4, 8'hFE); wr(3'd5, 8'hFF); wr(3'd6, 8'hFF); wr(3'd7, 8'hFF);
    wr(3'd0, 8'h01);
    check("wrap_0", count, 32'hFFFF_FFFE);
    idle(1); check("wrap_1", count, 32'hFFFF_FFFF);
    idle(1); check("wrap_2", count, 32'h0000_0000);
    idle(1); check("wrap_3", count, 32'h0000_0001);

    // 6: CTRL.clr while running, then reset mid-count
    idle(4);
    check("run_to_5", count, 32'd5);
    wr(3'd0, 8'h05);
    check("clr_count", count, 32'd0);
    read_expect(3'd0, 8'h01, "clr_ctrl_read");
    idle(3);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    advance();
    check("midrst_count", count, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    read_expect(3'd2, 8'h31, "midrst_pre");
    read_expect(3'd0, 8'h00, "midrst_ctrl");

    // Random traffic against the model
    wr(3'd2, 8'd1); wr(3'd0, 8'h03);
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 1) == 1);
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      if (a == 3'd0) begin
        d = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) d[2] = 1'b1;
      end
      if (a == 3'd2) d = 8'($urandom_range(0, 5));
      if (a == 3'd3) d = ($urandom_range(0, 15) == 0) ? 8'd1 : 8'd0;
      drive(r, c, w, a, d);
      advance();
    end

    idle(2);
    checking = 1'b0;
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
